// File: rtl/grf_pkg.sv
// Shared types and sizing for the ALU operand register file.
package grf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] raddr_t;

endpackage

// File: rtl/grf_read_port.sv
// One asynchronous read port: address mux with $0 forced to zero.
// Optional same-cycle write bypass when GRF_WRITE_BYPASS_EN is defined.
module grf_read_port
  import grf_pkg::*;
(
  input  raddr_t ra,
  input  word_t  regs [NREGS],
  input  logic   wr_commit,
  input  raddr_t wa,
  input  word_t  wd,
  output word_t  rd
);

`ifdef GRF_WRITE_BYPASS_EN
  always_comb begin
    rd = '0;
    if (ra != REG_ZERO) begin
      // wr_commit already excludes reset and $0, so only the address match is left
      if (wr_commit && (wa == ra)) rd = wd;
      else                         rd = regs[ra];
    end
  end
`else
  // Read-before-write: the write-side inputs play no part in this build.
  logic unused_wr;
  assign unused_wr = ^{wr_commit, wa, wd};

  always_comb begin
    rd = '0;
    if (ra != REG_ZERO) rd = regs[ra];
  end
`endif

endmodule

// File: rtl/alu_operand_grf.sv
// Register file feeding ALU_DA/ALU_DB, written back from ALU_DC.
// Define GRF_WRITE_BYPASS_EN for write-then-read forwarding on both read ports.
module alu_operand_grf
  import grf_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  raddr_t RF_RA1,
  input  raddr_t RF_RA2,
  input  logic   RF_WE,
  input  raddr_t RF_WA,
  input  word_t  RF_WD,
  output word_t  RF_RD1,
  output word_t  RF_RD2,
  output word_t  RF_WCNT
);

  word_t reg_view [NREGS];
  word_t wcnt_reg;
  logic  wr_commit;

  assign wr_commit   = RF_WE && !reset && (RF_WA != REG_ZERO);
  assign reg_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      word_t q_reg;

      always_ff @(posedge clk) begin
        if (reset)
          q_reg <= '0;
        else if (wr_commit && (RF_WA == raddr_t'(gi)))
          q_reg <= RF_WD;
      end

      assign reg_view[gi] = q_reg;
    end
  endgenerate

  // Counts committed writes only; rewrites of the same value still count.
  always_ff @(posedge clk) begin
    if (reset)          wcnt_reg <= '0;
    else if (wr_commit) wcnt_reg <= wcnt_reg + word_t'(1);
  end

  assign RF_WCNT = wcnt_reg;

  grf_read_port u_rd1 (
    .ra        (RF_RA1),
    .regs      (reg_view),
    .wr_commit (wr_commit),
    .wa        (RF_WA),
    .wd        (RF_WD),
    .rd        (RF_RD1)
  );

  grf_read_port u_rd2 (
    .ra        (RF_RA2),
    .regs      (reg_view),
    .wr_commit (wr_commit),
    .wa        (RF_WA),
    .wd        (RF_WD),
    .rd        (RF_RD2)
  );

endmodule

// File: doc/alu_operand_grf.md
Name: alu_operand_grf

Overview:
- General register file sitting on the other side of the ALU datapath.
- Supplies both ALU operands: RF_RD1 drives ALU_DA, RF_RD2 drives ALU_DB.
- Accepts the ALU result (ALU_DC) back as write data.
- Two asynchronous read ports, one synchronous write port, $0 hardwired to zero, synchronous clear on reset. Sits between instruction decode and the ALU in the single-cycle core.

Parameters:
- DATA_W, 32, register and port data width (matches ALU_DA/ALU_DB/ALU_DC).
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W = 32 entries.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- RF_RA1  input  ADDR_W  read address, port 1 (rs).
- RF_RA2  input  ADDR_W  read address, port 2 (rt).
- RF_WE  input  1  write enable.
- RF_WA  input  ADDR_W  write address (rd/rt).
- RF_WD  input  DATA_W  write data (ALU_DC or memory data).
- RF_RD1  output  DATA_W  read data, port 1 (to ALU_DA).
- RF_RD2  output  DATA_W  read data, port 2 (to ALU_DB).
- RF_WCNT  output  DATA_W  count of committed writes since reset (debug/verification).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Storage: NREGS x DATA_W array. Entry 0 is not stored and always reads 0.
- Reads are combinational, zero latency:
  - RF_RDn = 0 when RF_RAn == 0, else array[RF_RAn].
  - Reading an address while it is being written returns the old value; the new value is visible after the edge (unless the bypass feature is enabled).
- Write commits at a rising clk edge when RF_WE==1, reset==0 and RF_WA!=0.
  - Writes to $0 are dropped silently and do not increment RF_WCNT.
- Reset: at a rising edge with reset==1:
  - All entries 1..NREGS-1 become 0 and RF_WCNT becomes 0.
  - Reset has priority over a simultaneous write; that write is lost.
  - Reset asserted mid-sequence clears state on that edge. No write issued in the same cycle survives.
- RF_RD1/RF_RD2 after reset: 0 for every address.
- RF_WCNT:
  - Increments by 1 on every committed write.
  - Wraps from 2**DATA_W-1 to 0.
  - Rewriting the same value still counts.
- Both read ports may address the same register, or both may address the write target; each port resolves independently.
- No X propagation: with reset never asserted the array is undefined. Benches must reset first.
- Out-of-range addresses are impossible (ADDR_W bits cover all NREGS).

Optional Feature:
- Macro: GRF_WRITE_BYPASS_EN.
- Defined: if RF_WE==1, reset==0, RF_WA!=0 and RF_WA==RF_RAn, then RF_RDn = RF_WD in the same cycle (write-then-read semantics). The array update is unchanged.
- Undefined: read-before-write semantics as above. The macro changes only the read mux.

Decomposition:
- Shared package grf_pkg holds:
  - localparams DATA_W=32, ADDR_W=5, NREGS=32.
  - REG_ZERO=5'd0.
  - typedef word_t (DATA_W bits) and typedef raddr_t (ADDR_W bits).
- One natural sub-module, grf_read_port: the address-to-data mux with the $0 override and the optional bypass compare. Instantiate it twice.
- Write logic and RF_WCNT stay in the top module.

Test Plan:
- Reset then read all 32 addresses on both ports -> every RF_RD1/RF_RD2 = 32'h0; RF_WCNT = 0.
- Write WA=5, WD=32'h0000_0001; next cycle write WA=6, WD=32'h0000_0002. Then RA1=5, RA2=6 -> RD1=1, RD2=2, RF_WCNT=2. This is the ALU add operand pair.
- Write WA=0, WD=32'hDEAD_BEEF -> RD1 with RA1=0 stays 0; RF_WCNT unchanged.
- Same-cycle write WA=7, WD=32'h1234_5678 with RA1=7, old value 0:
  - Macro off: RD1=0 before the edge, 32'h1234_5678 after.
  - Macro on: RD1=32'h1234_5678 before the edge.
- Reg 9 = 32'hFFFF_FFFF, then assert reset together with WE=1, WA=9, WD=32'h5 -> after the edge RD(9)=0 and RF_WCNT=0.
- Feed RF_RD1/RF_RD2 into the ALU with ALUOp=3'b001 and write ALU_DC back to reg 10 -> reg 10 equals the expected ALU result for operands 2 and 1. Loop 100 random writes and check against a scoreboard array.
